bcd_scan_counter: RTL and testbench
===================================

Name: bcd_scan_counter

Overview:
- 4-digit BCD up/down counter with an integrated display scan multiplexer.
- Sits directly upstream of the 7-segment decoder: drives its 4-bit COUNT digit code and the digit anode enables.
- Emits 4'b1111 as the blank code; the decoder renders that code as all segments off.
- Provides a prescaled count tick, synchronous clear and load, and a wrap/borrow pulse.

Parameters:
- TICK_DIV, 50_000_000: CLK cycles per count step while EN=1. Legal range is 1 or more; a value of 1 steps every cycle.
- SCAN_DIV, 50_000: CLK cycles per displayed digit slot. Legal range is 1 or more.
- BLANK_LZ, 1: 1 enables leading-zero blanking; 0 always shows all four digits.

Ports:
- CLK, input, 1: system clock. All logic is on the rising edge.
- RST, input, 1: reset, synchronous and active-high.
- EN, input, 1: count enable. When 0 the prescaler freezes and there is no step.
- UP, input, 1: direction, 1 = increment, 0 = decrement. Sampled on the tick cycle.
- CLR, input, 1: synchronous clear of the value and the prescaler.
- LOAD, input, 1: synchronous load of LOAD_VAL.
- LOAD_VAL, input, 16: four BCD nibbles; [15:12] is the thousands digit, [3:0] the units digit.
- VALUE, output, 16: current BCD count, registered.
- CARRY, output, 1: one-cycle pulse on wrap 9999->0000 (up) or 0000->9999 (down).
- COUNT, output, 4: digit code for the 7-seg decoder: a BCD digit 0-9, or 4'b1111 for blank.
- AN, output, 4: active-low one-hot digit enable. AN[0] is the units digit.

Behaviour:
- Reset (RST=1 at a clock edge):
  - VALUE=0, CARRY=0, COUNT=4'b0000, AN=4'b1110.
  - Prescaler=0, scan counter=0, digit index=0.
  - RST overrides every other input.
- Value-update priority per cycle: RST > CLR > LOAD > tick.
  - CLR: VALUE=0, prescaler=0, no CARRY.
  - LOAD: each nibble of LOAD_VAL above 9 is stored as 0; valid nibbles are stored unchanged. Prescaler=0, no CARRY.
- Prescaler:
  - With EN=1 it counts 0..TICK_DIV-1. The tick is the cycle in which it equals TICK_DIV-1; it then returns to 0.
  - With EN=0 it holds its value.
  - A tick that coincides with CLR or LOAD is discarded.
- Count step on a tick:
  - UP=1: the units digit increments. A digit at 9 becomes 0 and carries into the next digit, rippling within the same cycle.
  - UP=0: the units digit decrements. A digit at 0 becomes 9 and borrows from the next digit.
  - The updated VALUE is visible on the cycle after the tick edge.
  - CARRY=1 for exactly that one cycle only when all four digits wrap. Otherwise CARRY=0.
- Scan:
  - The scan counter runs 0..SCAN_DIV-1 continuously and is independent of EN, CLR and LOAD.
  - At its terminal count the digit index advances 0->1->2->3->0.
- Display outputs, registered: each cycle, AN and COUNT are computed from the current index and the current VALUE.
  - AN = ~(1 << index).
  - COUNT = VALUE nibble[index], or 4'b1111 when blanked.
  - Latency from a VALUE or index change to COUNT/AN is 1 cycle.
- Blanking, when BLANK_LZ=1:
  - Digit i (i = 1..3) is blanked iff it and every higher digit are 0.
  - Digit 0 is never blanked, so VALUE=0 shows "   0".
  - With BLANK_LZ=0 nothing is blanked.
- COUNT never takes the codes 4'b1010..4'b1110.
- Reset mid-scan or mid-count returns everything to the reset values on the next edge. No partial step survives.

Decomposition:
- Shared package holds:
  - BLANK_CODE = 4'b1111.
  - NUM_DIGITS = 4.
  - BCD digit type: 4 bits.
  - The LOAD sanitising rule: nibble above 9 is stored as 0.
- One natural sub-module, bcd_digit: a single-digit up/down cell with inputs step_in, up, and load/clear, and a carry/borrow output. It is chained four times.
- The prescaler, scan counter, blanking logic and output registers stay in bcd_scan_counter.

Test Plan (TICK_DIV=2, SCAN_DIV=3, BLANK_LZ=1 unless noted):
- Reset, then hold EN=0 for 20 cycles -> VALUE=0x0000, CARRY=0. COUNT/AN rotate every 3 cycles:
  - (0, 4'b1110)
  - (F, 4'b1101)
  - (F, 4'b1011)
  - (F, 4'b0111)
- LOAD 0x9998, then EN=1, UP=1 -> VALUE steps to 0x9999, then 0x0000 with CARRY high for exactly 1 cycle, then 0x0001.
- LOAD 0x0001, then EN=1, UP=0 -> VALUE 0x0000, then 0x9999 with a one-cycle CARRY pulse. All four digits display unblanked.
- LOAD 0x0A5F -> VALUE=0x0050. The display shows digit0=0, digit1=5, digit2=F (blank), digit3=F (blank). With BLANK_LZ=0, digits 2 and 3 show 0.
- Assert CLR on the same cycle as a tick at VALUE=0x0123 -> VALUE=0x0000, CARRY=0, prescaler restarts. The next step occurs exactly TICK_DIV cycles after CLR deasserts.
- Assert RST during a scan of index 2 with LOAD=1 -> on the next cycle VALUE=0, AN=4'b1110, COUNT=0. LOAD is ignored.

Source files
------------

// File: rtl/bcd_scan_counter_pkg.sv
// Shared types and constants for the BCD scan counter.
// Digit type, blank code, digit count and load sanitising.
package bcd_scan_counter_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BLANK_CODE = 4'b1111;

  // Nibbles that are not a decimal digit load as 0.
  function automatic bcd_t bcd_sanitize(input bcd_t d);
    return (d > 4'd9) ? 4'd0 : d;
  endfunction

endpackage

// File: rtl/bcd_scan_counter_digit.sv
// Single BCD digit cell: clear/load/step up or down.
// Ports: clk, rst, clr, load, load_val, step_in, up -> digit, carry_out.
module bcd_digit
  import bcd_scan_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  bcd_t load_val,
  input  logic step_in,
  input  logic up,
  output bcd_t digit,
  output logic carry_out
);

  // Combinational so a wrap ripples through all cells in one cycle.
  assign carry_out = step_in &&
    (up ? (digit == 4'd9) : (digit == 4'd0));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= bcd_sanitize(load_val);
    end else if (step_in) begin
      if (up) begin
        digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
      end else begin
        digit <= (digit == 4'd0) ? 4'd9 : digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// 4-digit BCD up/down counter with 7-seg scan mux.
// In: CLK RST EN UP CLR LOAD LOAD_VAL. Out: VALUE CARRY COUNT AN.
module bcd_scan_counter
  import bcd_scan_counter_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000,
  parameter int BLANK_LZ = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        UP,
  input  logic        CLR,
  input  logic        LOAD,
  input  logic [15:0] LOAD_VAL,
  output logic [15:0] VALUE,
  output logic        CARRY,
  output logic [3:0]  COUNT,
  output logic [3:0]  AN
);

  localparam int PW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCN_MAX = SW'(SCAN_DIV - 1);

  logic [PW-1:0] pre;
  logic [SW-1:0] scnt;
  logic [1:0]    idx;
  logic          tick;
  logic          step0;

  bcd_t dig [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] cy;
  logic [NUM_DIGITS-1:0] step;
  logic [NUM_DIGITS-1:0] blank;

  assign tick  = EN && (pre == PRE_MAX);
  // A tick landing on CLR or LOAD is dropped.
  assign step0 = tick && !CLR && !LOAD;
  assign step  = {cy[NUM_DIGITS-2:0], step0};

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    bcd_digit u_dig (
      .clk      (CLK),
      .rst      (RST),
      .clr      (CLR),
      .load     (LOAD),
      .load_val (LOAD_VAL[4*i +: 4]),
      .step_in  (step[i]),
      .up       (UP),
      .digit    (dig[i]),
      .carry_out(cy[i])
    );
  end

  assign VALUE = {dig[3], dig[2], dig[1], dig[0]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      pre <= '0;
    end else if (CLR || LOAD) begin
      pre <= '0;
    end else if (EN) begin
      pre <= tick ? '0 : pre + 1'b1;
    end
  end

  // Full wrap only when the top cell carries out.
  always_ff @(posedge CLK) begin
    if (RST) begin
      CARRY <= 1'b0;
    end else begin
      CARRY <= cy[NUM_DIGITS-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      scnt <= '0;
      idx  <= 2'd0;
    end else if (scnt == SCN_MAX) begin
      scnt <= '0;
      idx  <= idx + 2'd1;
    end else begin
      scnt <= scnt + 1'b1;
    end
  end

  // Digit i blanks only if it and all higher digits are 0.
  always_comb begin
    blank = '0;
    if (BLANK_LZ != 0) begin
      blank[3] = (dig[3] == 4'd0);
      blank[2] = blank[3] && (dig[2] == 4'd0);
      blank[1] = blank[2] && (dig[1] == 4'd0);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      COUNT <= 4'b0000;
      AN    <= 4'b1110;
    end else begin
      AN    <= ~(4'b0001 << idx);
      COUNT <= blank[idx] ? BLANK_CODE : dig[idx];
    end
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Randomized self-checking bench for bcd_scan_counter.
// Two instances (blanking on/off) vs. an arithmetic model.
module tb_bcd_scan_counter;

  localparam int TD = 2;
  localparam int SD = 3;

  logic        CLK = 1'b0;
  logic        RST, EN, UP, CLR, LOAD;
  logic [15:0] LOAD_VAL;
  logic [15:0] val1, val0;
  logic        cy1, cy0;
  logic [3:0]  cnt1, cnt0, an1, an0;

  int nchecks = 0;
  int nerrs   = 0;

  always #5 CLK = ~CLK;

  bcd_scan_counter #(.TICK_DIV(TD), .SCAN_DIV(SD), .BLANK_LZ(1)) u_dut (
    .CLK(CLK), .RST(RST), .EN(EN), .UP(UP), .CLR(CLR),
    .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .VALUE(val1),
    .CARRY(cy1), .COUNT(cnt1), .AN(an1)
  );

  bcd_scan_counter #(.TICK_DIV(TD), .SCAN_DIV(SD), .BLANK_LZ(0)) u_dut0 (
    .CLK(CLK), .RST(RST), .EN(EN), .UP(UP), .CLR(CLR),
    .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .VALUE(val0),
    .CARRY(cy0), .COUNT(cnt0), .AN(an0)
  );

  // Model: value as a plain integer 0..9999.
  int   mval, mpre, mscan, midx;
  bit   armed = 0;
  logic e_carry;
  logic [3:0] e_cnt1, e_cnt0, e_an;

  function automatic int pow10(input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++)
      r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic int from_load(input logic [15:0] lv);
    int v = 0;
    int n;
    for (int i = 0; i < 4; i++) begin
      n = int'(lv[4*i +: 4]);
      if (n > 9) n = 0;
      v = v + n * pow10(i);
    end
    return v;
  endfunction

  always @(posedge CLK) begin
    int d;
    logic [3:0] oh;
    bit tick;
    if (RST) begin
      mval = 0; mpre = 0; mscan = 0; midx = 0;
      e_carry = 0; e_cnt1 = 0; e_cnt0 = 0;
      e_an = 4'b1110;
      armed = 1;
    end else begin
      d = (mval / pow10(midx)) % 10;
      oh = 4'b0001 << midx;
      e_an = ~oh;
      e_cnt0 = 4'(d);
      e_cnt1 = (midx > 0 && mval < pow10(midx)) ? 4'hF : 4'(d);
      if (mscan == SD - 1) begin
        mscan = 0;
        midx = (midx + 1) % 4;
      end else begin
        mscan++;
      end
      tick = EN && (mpre == TD - 1);
      e_carry = 0;
      if (CLR) begin
        mval = 0; mpre = 0;
      end else if (LOAD) begin
        mval = from_load(LOAD_VAL); mpre = 0;
      end else if (EN) begin
        mpre = tick ? 0 : mpre + 1;
        if (tick) begin
          if (UP) begin
            e_carry = (mval == 9999);
            mval = (mval + 1) % 10000;
          end else begin
            e_carry = (mval == 0);
            mval = (mval + 9999) % 10000;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (armed) begin
      chk("value_lz1", val1, to_bcd(mval));
      chk("value_lz0", val0, to_bcd(mval));
      chk("carry_lz1", 16'(cy1), 16'(e_carry));
      chk("carry_lz0", 16'(cy0), 16'(e_carry));
      chk("an_lz1", 16'(an1), 16'(e_an));
      chk("an_lz0", 16'(an0), 16'(e_an));
      chk("count_lz1", 16'(cnt1), 16'(e_cnt1));
      chk("count_lz0", 16'(cnt0), 16'(e_cnt0));
    end
  end

  task automatic cyc();
    @(negedge CLK);
  endtask

  initial begin
    bit found;
    RST = 1; EN = 0; UP = 1; CLR = 0; LOAD = 0;
    LOAD_VAL = '0;
    cyc(); cyc();
    chk("rst_value", val1, 16'h0000);
    chk("rst_an", 16'(an1), 16'h000E);
    chk("rst_count", 16'(cnt1), 16'h0000);
    chk("rst_carry", 16'(cy1), 16'h0000);

    RST = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      case (k)
        4:  begin chk("rot1_an", 16'(an1), 16'hD);
                  chk("rot1_cnt", 16'(cnt1), 16'hF); end
        7:  begin chk("rot2_an", 16'(an1), 16'hB);
                  chk("rot2_cnt", 16'(cnt1), 16'hF); end
        10: begin chk("rot3_an", 16'(an1), 16'h7);
                  chk("rot3_cnt", 16'(cnt1), 16'hF); end
        13: begin chk("rot0_an", 16'(an1), 16'hE);
                  chk("rot0_cnt", 16'(cnt1), 16'h0); end
        default: ;
      endcase
    end
    chk("idle_value", val1, 16'h0000);

    LOAD = 1; LOAD_VAL = 16'h9998; cyc();
    LOAD = 0; EN = 1; UP = 1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      case (k)
        2: chk("up_9999", val1, 16'h9999);
        4: begin chk("up_wrap", val1, 16'h0000);
                 chk("up_carry", 16'(cy1), 16'h1); end
        5: chk("up_carry_end", 16'(cy1), 16'h0);
        6: chk("up_0001", val1, 16'h0001);
        default: ;
      endcase
    end

    EN = 0; LOAD = 1; LOAD_VAL = 16'h0001; cyc();
    LOAD = 0; EN = 1; UP = 0;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      case (k)
        2: chk("dn_0000", val1, 16'h0000);
        4: begin chk("dn_wrap", val1, 16'h9999);
                 chk("dn_carry", 16'(cy1), 16'h1); end
        5: chk("dn_carry_end", 16'(cy1), 16'h0);
        default: ;
      endcase
    end
    EN = 0;
    repeat (12) cyc();

    LOAD = 1; LOAD_VAL = 16'h0A5F; cyc();
    LOAD = 0;
    chk("load_sanitize", val1, 16'h0050);
    for (int k = 0; k < 13; k++) begin
      cyc();
      if (an1 == 4'b1011) begin
        chk("blank_d2", 16'(cnt1), 16'hF);
        chk("noblank_d2", 16'(cnt0), 16'h0);
      end
      if (an1 == 4'b1101) chk("show_d1", 16'(cnt1), 16'h5);
    end

    LOAD = 1; LOAD_VAL = 16'h0123; cyc();
    LOAD = 0; EN = 1; UP = 1; cyc();
    CLR = 1; cyc();
    CLR = 0;
    chk("clr_value", val1, 16'h0000);
    chk("clr_carry", 16'(cy1), 16'h0);
    cyc();
    chk("clr_hold", val1, 16'h0000);
    cyc();
    chk("clr_step", val1, 16'h0001);

    EN = 0;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      cyc();
      if (an1 == 4'b1011) found = 1;
    end
    nchecks++;
    if (!found) begin
      nerrs++;
      $display("FAIL scan_idx2_timeout: got none expected an=1011");
    end
    RST = 1; LOAD = 1; LOAD_VAL = 16'h1234; EN = 1; cyc();
    RST = 0; LOAD = 0; EN = 0;
    chk("rst_mid_value", val1, 16'h0000);
    chk("rst_mid_an", 16'(an1), 16'hE);
    chk("rst_mid_count", 16'(cnt1), 16'h0);

    for (int k = 0; k < 4000; k++) begin
      RST  = ($urandom_range(0, 299) == 0);
      CLR  = ($urandom_range(0, 79) == 0);
      LOAD = ($urandom_range(0, 39) == 0);
      EN   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) UP = ~UP;
      case ($urandom_range(0, 3))
        0: LOAD_VAL = 16'($urandom);
        1: LOAD_VAL = 16'h9995;
        2: LOAD_VAL = 16'h0004;
        default: LOAD_VAL = to_bcd($urandom_range(0, 9999));
      endcase
      cyc();
    end
    RST = 0; CLR = 0; LOAD = 0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors",
             nchecks, nerrs);
    $finish;
  end

endmodule
